// File: rtl/dmem_bus_if_pkg.sv
// Shared RV32I data-memory definitions: bus SIZE encodings, funct3 load/store
// codes, the bus-interface FSM state type and small decode helpers.
package rv32i_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic {
    CAUSE_MISALIGNED,
    CAUSE_TIMEOUT
  } cause_e;

  // Undefined width codes (011, 110, 111) fall into the word case.
  function automatic size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (size_of(funct3))
      SIZE_HALF: return off[0];
      SIZE_WORD: return |off;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_if_if.sv
// Interfaces used by dmem_bus_if.
//   dmem_req_if  : MEM-stage side. master = pipeline, slave = dmem_bus_if.
//     req/we/funct3/addr/wdata -> ; <- stall/rdata/done/misaligned/bus_err
//   dmem_dbus_if : external data bus. master = dmem_bus_if, slave = memory.
//     DAD/ddt_out/MREQ/WRITE/SIZE -> ; <- ddt_in/ACKD_n
interface dmem_req_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        misaligned;
  logic        bus_err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  stall, rdata, done, misaligned, bus_err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output stall, rdata, done, misaligned, bus_err
  );
endinterface

interface dmem_dbus_if;
  logic [31:0] DAD;
  logic [31:0] ddt_out;
  logic [31:0] ddt_in;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  modport master (
    output DAD, ddt_out, MREQ, WRITE, SIZE,
    input  ddt_in, ACKD_n
  );

  modport slave (
    input  DAD, ddt_out, MREQ, WRITE, SIZE,
    output ddt_in, ACKD_n
  );
endinterface

// File: rtl/dmem_bus_if_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering.
//   st_size/wdata -> st_lanes : store data replicated onto little-endian lanes
//   ld_funct3/ld_off/ld_raw -> ld_data : load lane extract plus sign/zero extend
module dmem_lane_align
  import rv32i_pkg::*;
(
  input  size_e       st_size,
  input  logic [31:0] wdata,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  always_comb begin
    st_lanes = wdata;
    case (st_size)
      SIZE_BYTE: st_lanes = {4{wdata[7:0]}};
      SIZE_HALF: st_lanes = {2{wdata[15:0]}};
      default:   st_lanes = wdata;
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ld_off)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    sext    = ~ld_funct3[2];
    ld_data = ld_raw;
    case (size_of(ld_funct3))
      SIZE_BYTE: ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{sext & ld_half[15]}}, ld_half};
      default:   ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: turns a single-cycle MEM-stage load/store into a multi-cycle
// external bus transaction, stalling the pipeline until ACKD_n or timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   pipe       : dmem_req_if.slave (request in, stall/rdata/pulses out)
//   bus        : dmem_dbus_if.master (registered DAD/ddt_out/MREQ/WRITE/SIZE)
// The DDT pad (DDT = WRITE ? ddt_out : 'z) is formed by the pad ring from
// bus.ddt_out/bus.WRITE; this block only sees the split in/out data.
module dmem_bus_if
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        clk,
  input logic        rst_n,
  dmem_req_if.slave  pipe,
  dmem_dbus_if.master bus
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

  state_e      state, state_next;
  cause_e      cause_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic [8:0]  cnt_inc;
  logic [31:0] rdata_q;

  logic        mreq_q;
  logic        write_q;
  size_e       size_q;
  logic [31:0] dad_q;
  logic [31:0] ddt_q;

  logic [31:0] st_lanes;
  logic [31:0] ld_data;

  dmem_lane_align u_align (
    .st_size   (size_of(pipe.funct3)),
    .wdata     (pipe.wdata),
    .st_lanes  (st_lanes),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_raw    (bus.ddt_in),
    .ld_data   (ld_data)
  );

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (pipe.req)
          state_next = is_misaligned(pipe.funct3, pipe.addr[1:0]) ? S_ERR : S_ACCESS;
      end
      S_ACCESS: begin
        if (!bus.ACKD_n)
          state_next = S_DONE;
        else if (cnt_inc >= TIMEOUT_LIM)
          state_next = S_ERR;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs are loaded on the accepting edge so they are already stable
  // during the first ACCESS cycle, and drop on the edge that leaves ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cause_q  <= CAUSE_MISALIGNED;
      funct3_q <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      mreq_q   <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      dad_q    <= '0;
      ddt_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (state_next == S_ACCESS) begin
            funct3_q <= pipe.funct3;
            off_q    <= pipe.addr[1:0];
            cnt_q    <= '0;
            mreq_q   <= 1'b1;
            write_q  <= pipe.we;
            size_q   <= size_of(pipe.funct3);
            dad_q    <= {pipe.addr[31:2], 2'b00};
            ddt_q    <= st_lanes;
          end else if (state_next == S_ERR) begin
            cause_q <= CAUSE_MISALIGNED;
          end
        end
        S_ACCESS: begin
          if (state_next == S_DONE) begin
            if (!write_q)
              rdata_q <= ld_data;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (state_next == S_ERR)
              cause_q <= CAUSE_TIMEOUT;
          end
          if (state_next != S_ACCESS) begin
            mreq_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pipe.stall      = pipe.req & ((state == S_IDLE) | (state == S_ACCESS));
  assign pipe.done       = (state == S_DONE);
  assign pipe.misaligned = (state == S_ERR) & (cause_q == CAUSE_MISALIGNED);
  assign pipe.bus_err    = (state == S_ERR) & (cause_q == CAUSE_TIMEOUT);
  assign pipe.rdata      = (state == S_ERR) ? '0 : rdata_q;

  assign bus.MREQ    = mreq_q;
  assign bus.WRITE   = write_q;
  assign bus.SIZE    = size_q;
  assign bus.DAD     = dad_q;
  assign bus.ddt_out = ddt_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed self-checking bench for dmem_bus_if (TIMEOUT_CYCLES = 4).
module tb_dmem_bus_if;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  dmem_req_if  pipe ();
  dmem_dbus_if bus ();

  dmem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pipe),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot of one transaction, filled in by run_access.
  logic        snap_stall0, snap_stall1, snap_mreq, snap_write;
  logic [1:0]  snap_size;
  logic [31:0] snap_dad, snap_ddt;
  logic        res_done;
  int          res_cyc;
  logic [31:0] res_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request starting at cycle 0; ACKD_n is low only in cycle
  // waits+1. Records cycle-0/1 observations and the done cycle index.
  task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] di, input int waits);
    pipe.req = 1'b1; pipe.we = w; pipe.funct3 = f3; pipe.addr = a; pipe.wdata = wd;
    bus.ddt_in = di;
    res_done = 1'b0; res_cyc = -1; res_rdata = '0;
    for (int k = 0; k < 40; k++) begin
      bus.ACKD_n = (k == waits + 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k == 0) snap_stall0 = pipe.stall;
      if (k == 1) begin
        snap_stall1 = pipe.stall; snap_mreq = bus.MREQ; snap_write = bus.WRITE;
        snap_size = bus.SIZE; snap_dad = bus.DAD; snap_ddt = bus.ddt_out;
      end
      if (pipe.done) begin
        res_done = 1'b1; res_cyc = k; res_rdata = pipe.rdata;
        break;
      end
      tick();
    end
    tick();
    pipe.req = 1'b0; bus.ACKD_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.MREQ !== 1'b0) begin n_fail++; $display("FAIL reset_mreq: got %b want 0", bus.MREQ); end
    n_tests++; if (bus.WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", bus.WRITE); end
    n_tests++; if (bus.SIZE !== 2'b00) begin n_fail++; $display("FAIL reset_size: got %b want 00", bus.SIZE); end
    n_tests++; if (bus.DAD !== 32'h0) begin n_fail++; $display("FAIL reset_dad: got %h want 0", bus.DAD); end
    n_tests++; if (bus.ddt_out !== 32'h0) begin n_fail++; $display("FAIL reset_ddt: got %h want 0", bus.ddt_out); end
    n_tests++; if (pipe.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", pipe.rdata); end
    n_tests++; if ({pipe.stall, pipe.done, pipe.misaligned, pipe.bus_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {pipe.stall, pipe.done, pipe.misaligned, pipe.bus_err});
    end
  endtask

  task automatic test_lw();
    run_access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
    n_tests++; if (res_done !== 1'b1 || res_cyc != 2) begin n_fail++; $display("FAIL lw_done_cycle: got %0d want 2", res_cyc); end
    n_tests++; if (res_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", res_rdata); end
    n_tests++; if ({snap_stall0, snap_stall1} !== 2'b11) begin n_fail++; $display("FAIL lw_stall: got %b want 11", {snap_stall0, snap_stall1}); end
    n_tests++; if (snap_size !== 2'b10) begin n_fail++; $display("FAIL lw_size: got %b want 10", snap_size); end
    n_tests++; if ({snap_mreq, snap_write} !== 2'b10) begin n_fail++; $display("FAIL lw_mreq_write: got %b want 10", {snap_mreq, snap_write}); end
    n_tests++; if (snap_dad !== 32'h0000_0104) begin n_fail++; $display("FAIL lw_dad: got %h want 00000104", snap_dad); end
    @(negedge clk);
    n_tests++; if ({pipe.done, bus.MREQ} !== 2'b00) begin n_fail++; $display("FAIL lw_after: got %b want 00", {pipe.done, bus.MREQ}); end
  endtask

  task automatic test_load_extend();
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
    n_tests++; if (res_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", res_rdata); end
    n_tests++; if (snap_size !== 2'b00) begin n_fail++; $display("FAIL lb_size: got %b want 00", snap_size); end
    run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
    n_tests++; if (res_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", res_rdata); end
    run_access(1'b0, 3'b001, 32'h0000_0206, 32'h0, 32'h8001_7FFF, 0);
    n_tests++; if (res_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8001", res_rdata); end
    run_access(1'b0, 3'b101, 32'h0000_0206, 32'h0, 32'h8001_7FFF, 0);
    n_tests++; if (res_rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008001", res_rdata); end
    run_access(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h1234_7F00, 0);
    n_tests++; if (res_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos_rdata: got %h want 0000007f", res_rdata); end
  endtask

  task automatic test_store();
    run_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3);
    n_tests++; if (snap_write !== 1'b1) begin n_fail++; $display("FAIL sh_write: got %b want 1", snap_write); end
    n_tests++; if (snap_ddt !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_ddt: got %h want abcdabcd", snap_ddt); end
    n_tests++; if (snap_dad !== 32'h0000_0200) begin n_fail++; $display("FAIL sh_dad: got %h want 00000200", snap_dad); end
    n_tests++; if (snap_size !== 2'b01) begin n_fail++; $display("FAIL sh_size: got %b want 01", snap_size); end
    n_tests++; if (res_done !== 1'b1 || res_cyc != 5) begin n_fail++; $display("FAIL sh_done_cycle: got %0d want 5", res_cyc); end
    run_access(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0, 0);
    n_tests++; if (snap_ddt !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_ddt: got %h want abababab", snap_ddt); end
    n_tests++; if (snap_dad !== 32'h0) begin n_fail++; $display("FAIL sb_dad: got %h want 0", snap_dad); end
    run_access(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0, 0);
    n_tests++; if (snap_ddt !== 32'h1122_3344) begin n_fail++; $display("FAIL sw_ddt: got %h want 11223344", snap_ddt); end
  endtask

  task automatic test_misaligned();
    pipe.req = 1'b1; pipe.we = 1'b0; pipe.funct3 = 3'b010; pipe.addr = 32'h0000_0102;
    bus.ACKD_n = 1'b1;
    @(negedge clk);
    n_tests++; if ({pipe.stall, bus.MREQ} !== 2'b10) begin n_fail++; $display("FAIL mis_c0: got %b want 10", {pipe.stall, bus.MREQ}); end
    tick();
    @(negedge clk);
    n_tests++; if (pipe.misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", pipe.misaligned); end
    n_tests++; if ({bus.MREQ, pipe.stall, pipe.bus_err} !== 3'b000) begin n_fail++; $display("FAIL mis_c1: got %b want 000", {bus.MREQ, pipe.stall, pipe.bus_err}); end
    n_tests++; if (pipe.rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", pipe.rdata); end
    tick();
    pipe.req = 1'b0;
    @(negedge clk);
    n_tests++; if ({pipe.misaligned, bus.MREQ} !== 2'b00) begin n_fail++; $display("FAIL mis_after: got %b want 00", {pipe.misaligned, bus.MREQ}); end
    tick();
    // Halfword at odd address is also rejected.
    pipe.req = 1'b1; pipe.we = 1'b1; pipe.funct3 = 3'b001; pipe.addr = 32'h0000_0005;
    tick();
    @(negedge clk);
    n_tests++; if ({pipe.misaligned, bus.MREQ} !== 2'b10) begin n_fail++; $display("FAIL mis_sh: got %b want 10", {pipe.misaligned, bus.MREQ}); end
    tick();
    pipe.req = 1'b0;
  endtask

  task automatic test_timeout();
    pipe.req = 1'b1; pipe.we = 1'b0; pipe.funct3 = 3'b010; pipe.addr = 32'h0000_0040;
    bus.ACKD_n = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    @(negedge clk);
    n_tests++; if ({bus.MREQ, pipe.bus_err, pipe.stall} !== 3'b101) begin n_fail++; $display("FAIL to_last_access: got %b want 101", {bus.MREQ, pipe.bus_err, pipe.stall}); end
    tick();
    @(negedge clk);
    n_tests++; if (pipe.bus_err !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", pipe.bus_err); end
    n_tests++; if ({bus.MREQ, pipe.stall, pipe.misaligned} !== 3'b000) begin n_fail++; $display("FAIL to_err_outs: got %b want 000", {bus.MREQ, pipe.stall, pipe.misaligned}); end
    n_tests++; if (pipe.rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", pipe.rdata); end
    tick();
    pipe.req = 1'b0;
    @(negedge clk);
    n_tests++; if (pipe.bus_err !== 1'b0) begin n_fail++; $display("FAIL to_after: got %b want 0", pipe.bus_err); end
    tick();
    run_access(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 0);
    n_tests++; if (res_done !== 1'b1 || res_cyc != 2 || res_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL to_next_req: got cyc %0d data %h want cyc 2 data 0badf00d", res_cyc, res_rdata);
    end
  endtask

  task automatic test_back_to_back();
    pipe.req = 1'b1; pipe.we = 1'b0; pipe.funct3 = 3'b010; pipe.addr = 32'h0000_0010;
    bus.ddt_in = 32'h0000_0055; bus.ACKD_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_tests++; if ({pipe.done, pipe.rdata} !== {1'b1, 32'h0000_0055}) begin n_fail++; $display("FAIL b2b_first: got %b %h want 1 00000055", pipe.done, pipe.rdata); end
    tick();
    pipe.addr = 32'h0000_0020; bus.ddt_in = 32'h0000_0066;
    @(negedge clk);
    n_tests++; if ({bus.MREQ, pipe.stall, pipe.done} !== 3'b010) begin n_fail++; $display("FAIL b2b_gap: got %b want 010", {bus.MREQ, pipe.stall, pipe.done}); end
    tick();
    @(negedge clk);
    n_tests++; if ({bus.MREQ, bus.DAD} !== {1'b1, 32'h0000_0020}) begin n_fail++; $display("FAIL b2b_second: got %b %h want 1 00000020", bus.MREQ, bus.DAD); end
    tick();
    @(negedge clk);
    n_tests++; if ({pipe.done, pipe.rdata} !== {1'b1, 32'h0000_0066}) begin n_fail++; $display("FAIL b2b_done: got %b %h want 1 00000066", pipe.done, pipe.rdata); end
    tick();
    pipe.req = 1'b0; bus.ACKD_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    pipe.req = 1'b1; pipe.we = 1'b1; pipe.funct3 = 3'b010; pipe.addr = 32'h0000_0300;
    pipe.wdata = 32'h1122_3344; bus.ACKD_n = 1'b1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.MREQ, bus.WRITE, bus.SIZE} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 0000", {bus.MREQ, bus.WRITE, bus.SIZE}); end
    n_tests++; if ({bus.DAD, bus.ddt_out} !== 64'h0) begin n_fail++; $display("FAIL rstmid_bus: got %h %h want 0 0", bus.DAD, bus.ddt_out); end
    n_tests++; if ({pipe.rdata, pipe.done, pipe.misaligned, pipe.bus_err} !== 35'h0) begin n_fail++; $display("FAIL rstmid_pipe: got %h %b want 0", pipe.rdata, {pipe.done, pipe.misaligned, pipe.bus_err}); end
    pipe.req = 1'b0;
    #1;
    n_tests++; if (pipe.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", pipe.stall); end
    tick();
    rst_n = 1'b1;
    tick();
    run_access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0);
    n_tests++; if (res_done !== 1'b1 || res_cyc != 2 || res_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL rstmid_fresh: got cyc %0d data %h want cyc 2 data cafef00d", res_cyc, res_rdata);
    end
    n_tests++; if ({snap_write, snap_dad} !== {1'b0, 32'h0000_0104}) begin n_fail++; $display("FAIL rstmid_fresh_bus: got %b %h want 0 00000104", snap_write, snap_dad); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    pipe.req = 1'b0; pipe.we = 1'b0; pipe.funct3 = 3'b000; pipe.addr = '0; pipe.wdata = '0;
    bus.ddt_in = '0; bus.ACKD_n = 1'b1;
    tick(); tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_lw();
    tick();
    test_load_extend();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_bus_if.md
# dmem_bus_if

Data-memory bus interface between the MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It turns a single-cycle load/store request from the pipeline into a multi-cycle bus transaction. It stalls the pipeline until the memory acknowledges, aligns store data to byte lanes, and extracts and sign- or zero-extends load data. It also flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: wait cycles with ACKD_n high before a bus error is raised (1..255)
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  MEM stage requests an access; held stable with all request fields while stall=1
- we  in  1  1: store, 0: load
- funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- stall  out  1  hold the pipeline
- rdata  out  32  extended load data; valid when done=1
- done  out  1  one-cycle pulse: access complete
- misaligned  out  1  one-cycle pulse: request rejected, no bus access
- bus_err  out  1  one-cycle pulse: timeout, transaction abandoned
- DAD  out  32  bus address, word-aligned (addr[31:2],2'b00)
- ddt_out  out  32  store data on byte lanes (top drives DDT when WRITE=1)
- ddt_in  in  32  DDT sampled value
- MREQ  out  1  bus request
- WRITE  out  1  bus write strobe
- SIZE  out  2  00 byte, 01 halfword, 10 word
- ACKD_n  in  1  0: memory completes this cycle

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE: if req=1 and the access is aligned, latch we/funct3/addr/wdata, clear the timeout counter, and go to ACCESS. If req=1 and the access is misaligned, go to ERR with cause=misaligned.
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
- ACCESS: MREQ=1, WRITE=latched we, SIZE from funct3[1:0], DAD from latched addr.
  - ACKD_n=0: for a load, capture the extended ddt_in into the rdata register; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, go to ERR with cause=timeout.
- DONE: done=1, stall=0, go to IDLE.
- ERR: misaligned or bus_err=1 according to cause, stall=0, rdata=0, go to IDLE.
- An undefined funct3 (011, 110, 111) is treated as a word access.
- stall = req & (state==IDLE | state==ACCESS).
- Store lanes are little-endian.
  - Byte: wdata[7:0] is replicated to all 4 lanes.
  - Half: wdata[15:0] is replicated to both halves.
  - Word: passed through unchanged.
- Load extract: byte lane = addr[1:0], half lane = addr[1]. Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- Reset values: state IDLE, MREQ/WRITE/stall/done/misaligned/bus_err 0, SIZE 00, DAD 0, ddt_out 0, rdata 0, counter 0.
- Reset asserted mid-transaction drops MREQ immediately (asynchronously). No partial write is reissued.

## Timing
- Minimum access: 3 cycles. Cycle 0 accepts req in IDLE, cycle 1 is ACCESS with ACKD_n=0, cycle 2 is DONE; the pipeline advances at the end of cycle 2.
- Each extra cycle with ACKD_n=1 adds one cycle of latency.
- Bus outputs (MREQ/WRITE/SIZE/DAD/ddt_out) are registered and stable for the whole of ACCESS.
- A req held high in DONE/ERR is not re-accepted. Back-to-back requests start at earliest one cycle after DONE.
- Timeout: ERR is entered on the cycle after the counter hits TIMEOUT_CYCLES; MREQ falls on that edge.
- A misaligned request produces its misaligned pulse 1 cycle after acceptance; MREQ never rises.

## Structure
- Shared package (rv32i_pkg): SIZE encodings, funct3 load/store codes, state enum.
- One sub-module: dmem_lane_align, purely combinational, containing store replicate plus load extract/extend. It is instantiated once and is reusable by a future cache.
- The DDT inout is resolved at top: DDT = WRITE ? ddt_out : z.

## Test plan
- LW addr 0x0000_0104, ACKD_n=0 in the first ACCESS cycle, ddt_in 0xDEAD_BEEF: done on cycle 2, rdata 0xDEAD_BEEF, stall high in cycles 0–1, SIZE=10.
- LB addr 0x0000_0103, ddt_in 0x8000_0000: rdata 0xFFFF_FF80. The same request as LBU gives rdata 0x0000_0080.
- SH addr 0x0000_0202, wdata 0x1234_ABCD, ACKD_n held high for 3 cycles then low: WRITE=1, ddt_out 0xABCD_ABCD, DAD 0x0000_0200, done after 6 cycles total.
- LW addr 0x0000_0102: misaligned pulse on cycle 1, MREQ stays 0, rdata 0.
- ACKD_n stuck high with TIMEOUT_CYCLES=4: bus_err pulse, MREQ drops, back to IDLE; the next request completes normally.
- rst_n pulsed low in the second ACCESS cycle: MREQ low immediately, all outputs at reset values, first request after release behaves as a fresh access.
